// File: rtl/rsnn_param_serializer.sv
// Serial parameter-load transmitter for the RSNN core: shifts parallel words out MSB-first
// on data_in/load_params and sequences per-word and end-of-frame acknowledges.
module rsnn_param_serializer #(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WORD_W-1:0]              word_in,
    input  logic                           word_valid,
    output logic                           word_ready,
    output logic                           data_in,
    output logic                           load_params,
    input  logic                           data_written,
    input  logic                           end_writing,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(NUM_WORDS+1)-1:0] words_sent
);

    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_WAIT_ACK,
        S_WAIT_END,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  words_sent_q, words_sent_d;
    logic              load_params_q, load_params_d;
    logic              data_in_q, data_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              final_ack;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            timer_q       <= '0;
            words_sent_q  <= '0;
            load_params_q <= 1'b0;
            data_in_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            timer_q       <= timer_d;
            words_sent_q  <= words_sent_d;
            load_params_q <= load_params_d;
            data_in_q     <= data_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        timer_d      = timer_q;
        words_sent_d = words_sent_q;
        final_ack    = data_written && (words_sent_q == LAST_WORD);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    words_sent_d = '0;
                    state_d      = S_WAIT_WORD;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_WORD: begin
                if (word_valid) begin
                    shreg_d  = word_in;
                    bitcnt_d = BIT_LAST;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Receiver strobes are only legal once the whole word has been sent
                if (data_written || end_writing) begin
                    state_d = S_ERROR;
                end else begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - BIT_W'(1);
                    if (bitcnt_q == '0) begin
                        timer_d = '0;
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (end_writing && !final_ack) begin
                    state_d = S_ERROR;
                end else if (data_written) begin
                    words_sent_d = words_sent_q + CNT_W'(1);
                    timer_d      = '0;
                    if (final_ack) begin
                        state_d = end_writing ? S_DONE : S_WAIT_END;
                    end else begin
                        state_d = S_WAIT_WORD;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_END: begin
                if (end_writing) begin
                    state_d = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        load_params_d = (state_d == S_SHIFT);
        data_in_d     = (state_d == S_SHIFT) && shreg_d[WORD_W-1];
        busy_d        = (state_d == S_WAIT_WORD) || (state_d == S_SHIFT) ||
                        (state_d == S_WAIT_ACK)  || (state_d == S_WAIT_END);
        done_d        = (state_d == S_DONE);
        error_d       = (state_d == S_ERROR);
    end

    assign word_ready  = (state_q == S_WAIT_WORD);
    assign data_in     = data_in_q;
    assign load_params = load_params_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign words_sent  = words_sent_q;

endmodule

// File: tb/tb_rsnn_param_serializer.sv
// Scoreboard bench for rsnn_param_serializer: driver pushes expected serial bits per word,
// a negedge monitor pops and compares them while load_params is high.
module tb_rsnn_param_serializer;

    localparam int unsigned WW = 8;
    localparam int unsigned NW = 2;
    localparam int unsigned TO = 15;
    localparam int unsigned CW = $clog2(NW + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic          data_in;
    logic          load_params;
    logic          data_written = 1'b0;
    logic          end_writing = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] words_sent;

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;
    int exp_done = 0;
    int run = 0;
    bit abort = 1'b0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    rsnn_param_serializer #(.WORD_W(WW), .NUM_WORDS(NW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready), .data_in(data_in),
        .load_params(load_params), .data_written(data_written),
        .end_writing(end_writing), .busy(busy), .done(done), .error(error),
        .words_sent(words_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: serial bits against the expected queue, and burst length per word
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (abort || reset) begin
            exp_bits.delete();
            run = 0;
        end else if (load_params === 1'b1) begin
            run++;
            if (exp_bits.size() == 0) chk("unexpected_bit", 32'(load_params), 0);
            else chk("data_in", 32'(data_in), 32'(exp_bits.pop_front()));
        end else if (run > 0) begin
            chk("lp_run_len", run, WW);
            run = 0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Reference: a word is transmitted as its bits from weight WW-1 down to 0
    task automatic push_word(input logic [WW-1:0] w);
        for (int i = WW - 1; i >= 0; i--) exp_bits.push_back(bit'((w >> i) & 1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word_ready"}, 32'(word_ready), 0);
        chk({tag, "_data_in"}, 32'(data_in), 0);
        chk({tag, "_load_params"}, 32'(load_params), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_words_sent"}, 32'(words_sent), 0);
    endtask

    // Offer a word; returns in the first SHIFT cycle
    task automatic send_word(input logic [WW-1:0] w, input int gap, input bit hold);
        bit ok = 1'b0;
        repeat (gap) step();
        word_in = w;
        word_valid = 1'b1;
        push_word(w);
        for (int i = 0; i < 40 && !ok; i++) begin
            if (word_ready) ok = 1'b1;
            step();
        end
        if (!hold) word_valid = 1'b0;
        chk("lp_first_bit", 32'(load_params), 1);
    endtask

    // Returns in the first WAIT_ACK cycle
    task automatic wait_ack_entry;
        bit ok = 1'b0;
        for (int i = 0; i < int'(WW) + 4 && !ok; i++) begin
            if (!load_params) ok = 1'b1;
            else step();
        end
        chk("reach_wait_ack", 32'(load_params), 0);
    endtask

    task automatic ack_word(input int d, input bit with_end, input int exp_cnt);
        repeat (d) step();
        data_written = 1'b1;
        end_writing = with_end;
        step();
        data_written = 1'b0;
        chk("words_sent", 32'(words_sent), exp_cnt);
        chk("error_after_ack", 32'(error), 0);
    endtask

    // Runs a whole frame from WAIT_WORD; returns in the DONE cycle
    task automatic frame_body(input bit force0, input logic [WW-1:0] w0);
        logic [WW-1:0] v;
        int d;
        bit we = 1'b0;
        for (int w = 0; w < int'(NW); w++) begin
            v = (force0 && w == 0) ? w0 : WW'($urandom);
            send_word(v, $urandom_range(0, 2), 1'b0);
            wait_ack_entry();
            d = ($urandom_range(0, 7) == 0) ? int'(TO) - 1 : $urandom_range(0, 6);
            we = (w == int'(NW) - 1) && ($urandom_range(0, 1) == 1);
            ack_word(d, we, w + 1);
        end
        if (!we) begin
            chk("done_early", 32'(done), 0);
            d = ($urandom_range(0, 7) == 0) ? int'(TO) - 1 : $urandom_range(0, 6);
            repeat (d) step();
            end_writing = 1'b1;
            step();
        end
        chk("done_pulse", 32'(done), 1);
        chk("busy_in_done", 32'(busy), 0);
        chk("words_sent_final", 32'(words_sent), NW);
        exp_done++;
        end_writing = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(word_ready), 0);

        // Nominal frame: 0xA5 then 0x3C, ack two cycles into WAIT_ACK, end with final ack
        pulse_start();
        chk("start_ready", 32'(word_ready), 1);
        chk("start_busy", 32'(busy), 1);
        send_word(8'hA5, 0, 1'b0);
        wait_ack_entry();
        ack_word(2, 1'b0, 1);
        send_word(8'h3C, 0, 1'b0);
        wait_ack_entry();
        ack_word(2, 1'b1, 2);
        chk("nom_done", 32'(done), 1);
        exp_done++;
        end_writing = 1'b0;
        step();
        chk("nom_done_once", 32'(done), 0);

        // Ack timeout: ERROR exactly TO cycles after WAIT_ACK entry
        pulse_start();
        send_word(WW'($urandom), 0, 1'b0);
        wait_ack_entry();
        repeat (TO - 1) step();
        chk("ack_to_not_yet", 32'(error), 0);
        step();
        chk("ack_to_error", 32'(error), 1);
        chk("ack_to_lp", 32'(load_params), 0);
        chk("ack_to_ready", 32'(word_ready), 0);
        chk("ack_to_busy", 32'(busy), 0);
        step();
        chk("error_sticky", 32'(error), 1);
        pulse_start();
        chk("restart_error", 32'(error), 0);
        chk("restart_ready", 32'(word_ready), 1);
        chk("restart_cnt", 32'(words_sent), 0);
        frame_body(1'b0, '0);
        step();

        // End-of-frame timeout in WAIT_END
        pulse_start();
        send_word(WW'($urandom), 0, 1'b0);
        wait_ack_entry();
        ack_word(1, 1'b0, 1);
        send_word(WW'($urandom), 0, 1'b0);
        wait_ack_entry();
        ack_word(0, 1'b0, 2);
        repeat (TO - 1) step();
        chk("end_to_not_yet", 32'(error), 0);
        step();
        chk("end_to_error", 32'(error), 1);
        chk("end_to_done", 32'(done), 0);

        // Premature end_writing while waiting for word 1's ack
        pulse_start();
        chk("pre_error_clear", 32'(error), 0);
        send_word(WW'($urandom), 0, 1'b0);
        wait_ack_entry();
        step();
        end_writing = 1'b1;
        step();
        end_writing = 1'b0;
        chk("pre_end_error", 32'(error), 1);
        chk("pre_end_cnt", 32'(words_sent), 0);
        chk("pre_end_done", 32'(done), 0);

        // Reset on the 4th bit, then a frame starting with 0xFF
        pulse_start();
        send_word(8'h5A, 0, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk_all_zero("mid_reset");
        reset = 1'b0;
        step();
        chk("post_reset_idle", 32'(word_ready), 0);
        pulse_start();
        frame_body(1'b1, 8'hFF);
        step();

        // word_valid held high throughout, start pulsed while busy
        word_in = 8'hC3;
        word_valid = 1'b1;
        repeat (2) step();
        chk("idle_valid_ignored", 32'(word_ready), 0);
        pulse_start();
        send_word(8'hC3, 0, 1'b1);
        word_in = 8'h96;
        pulse_start();
        wait_ack_entry();
        chk("busy_start_cnt", 32'(words_sent), 0);
        pulse_start();
        chk("busy_start_busy", 32'(busy), 1);
        ack_word(1, 1'b0, 1);
        send_word(8'h96, 0, 1'b1);
        word_in = 8'h0F;
        wait_ack_entry();
        ack_word(0, 1'b1, 2);
        chk("bp_done", 32'(done), 1);
        exp_done++;
        end_writing = 1'b0;
        step();
        word_valid = 1'b0;
        chk("bp_idle_ready", 32'(word_ready), 0);
        chk("bp_idle_lp", 32'(load_params), 0);

        // Receiver strobes during SHIFT are protocol errors
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            send_word(WW'($urandom), 0, 1'b0);
            step();
            abort = 1'b1;
            data_written = (k == 0);
            end_writing = (k == 1);
            step();
            data_written = 1'b0;
            end_writing = 1'b0;
            chk("shift_strobe_error", 32'(error), 1);
            chk("shift_strobe_lp", 32'(load_params), 0);
            chk("shift_strobe_ready", 32'(word_ready), 0);
            step();
            abort = 1'b0;
        end

        // Randomised frames, some restarted directly from the DONE cycle
        pulse_start();
        frame_body(1'b0, '0);
        for (int f = 0; f < 29; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                pulse_start();
            end else begin
                step();
                chk("rand_idle_done", 32'(done), 0);
                repeat ($urandom_range(0, 2)) step();
                pulse_start();
            end
            chk("rand_start_ready", 32'(word_ready), 1);
            chk("rand_start_cnt", 32'(words_sent), 0);
            frame_body(1'b0, '0);
        end
        step();
        chk("final_done_low", 32'(done), 0);
        step();
        chk("done_count", done_seen, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
